mult_complex_e: RTL and testbench

FFT twiddle-factor rotator. It multiplies one complex sample by e^(-jθ) and by e^(+jθ) at the same time, where θ = 2π·fi_deg/2^SIZE_DATA_FI. Both products are returned as fixed-point I/Q pairs. It sits inside FFT/IFFT butterfly stages; the TYPE parameter selects forward or inverse sign convention.

---
 rtl/mult_complex_e.sv | 220 ++++++++++++++++++++++
 tb/tb_mult_complex_e.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_complex_e.sv
// Twiddle rotator: multiplies x by e^(-j*theta) and e^(+j*theta) in parallel, theta = 2*pi*fi_deg/2^SIZE_DATA_FI.
// Latency: three register stages (capture + ROM lookup, products, add/round/saturate); one sample per clock.
// Backpressure: none; the pipeline always advances and the outputs hold their last valid result while idle.
module mult_complex_e #(
    parameter int    SIZE_DATA_FI  = 3,
    parameter int    DATA_FFT_SIZE = 16,
    parameter string TYPE          = "forvard",
    parameter string COMPENS_FP    = "add"
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic signed [DATA_FFT_SIZE-1:0] in_data_i,
    input  logic signed [DATA_FFT_SIZE-1:0] in_data_q,
    input  logic        [SIZE_DATA_FI-1:0]  fi_deg,
    output logic signed [DATA_FFT_SIZE-1:0] out_data_minus_i,
    output logic signed [DATA_FFT_SIZE-1:0] out_data_minus_q,
    output logic signed [DATA_FFT_SIZE-1:0] out_data_plus_i,
    output logic signed [DATA_FFT_SIZE-1:0] out_data_plus_q,
    output logic                            outValid
);

    localparam int W       = DATA_FFT_SIZE;
    localparam int CW      = 17;          // coefficient width, holds +/-32768
    localparam int PW      = W + CW;      // full-precision product width
    localparam int SW      = PW + 1;      // sum/difference width
    localparam int NUM_PTS = 1 << SIZE_DATA_FI;
    localparam int QUARTER = NUM_PTS / 4;

    // "inverse" exchanges the roles of the two products
    localparam bit SWAP_OUT = (TYPE == "inverse");
    // "add" rounds half-up before the >>15, otherwise plain floor
    localparam bit ROUND_EN = (COMPENS_FP == "add");

    localparam logic signed [SW-1:0] HALF_LSB = SW'(16384);
    localparam logic signed [SW-1:0] SAT_MAX  = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN  = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    // 2*pi in 2^-60 fixed point (pi = 0x3.243F6A8885A308D...)
    localparam logic signed [127:0] TWO_PI_FX = 128'sh6487ED5110B4611A;

    // round(32768*sin(2*pi*m/NUM_PTS)) for m in [0, NUM_PTS/4]; Taylor series in
    // 2^-60 fixed point, far more precise than needed to land on the right integer.
    function automatic logic signed [CW-1:0] sin_q(input int m);
        logic signed [127:0] x;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] r;
        x    = (TWO_PI_FX * 128'(m)) >>> SIZE_DATA_FI;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = (term * x) >>> 60;
            term = (term * x) >>> 60;
            term = -(term / 128'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        r = (sum * 128'sd32768 + (128'sd1 <<< 59)) >>> 60;
        return r[CW-1:0];
    endfunction

    // {C, S} for index k, folded onto the first quadrant so axis points are exact
    function automatic logic [2*CW-1:0] rom_entry(input int k);
        int                     quad;
        int                     m;
        logic signed [CW-1:0]   sa;
        logic signed [CW-1:0]   sb;
        quad = k / QUARTER;
        m    = k % QUARTER;
        sa   = sin_q(m);
        sb   = sin_q(QUARTER - m);
        case (quad)
            0:       return {sb, sa};
            1:       return {-sa, sb};
            2:       return {-sb, -sa};
            default: return {sa, -sb};
        endcase
    endfunction

    logic signed [CW-1:0] rom_c [NUM_PTS];
    logic signed [CW-1:0] rom_s [NUM_PTS];

    for (genvar g = 0; g < NUM_PTS; g++) begin : g_rom
        localparam logic [2*CW-1:0] ENT = rom_entry(g);
        assign rom_c[g] = ENT[2*CW-1:CW];
        assign rom_s[g] = ENT[CW-1:0];
    end

    // >>15 with optional half-LSB rounding, then clamp to the output range
    function automatic logic signed [W-1:0] scale_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        if (ROUND_EN) begin
            t = v + HALF_LSB;
        end else begin
            t = v;
        end
        t = t >>> 15;
        if (t > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (t < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return t[W-1:0];
    endfunction

    // pipeline state
    logic                 s1_vld_q, s1_vld_d;
    logic signed [W-1:0]  s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic signed [CW-1:0] s1_c_q, s1_c_d, s1_s_q, s1_s_d;

    logic                 s2_vld_q, s2_vld_d;
    logic signed [PW-1:0] s2_ic_q, s2_ic_d, s2_qs_q, s2_qs_d;
    logic signed [PW-1:0] s2_is_q, s2_is_d, s2_qc_q, s2_qc_d;

    logic                 out_vld_q, out_vld_d;
    logic signed [W-1:0]  out_mi_q, out_mi_d, out_mq_q, out_mq_d;
    logic signed [W-1:0]  out_pi_q, out_pi_d, out_pq_q, out_pq_d;

    logic signed [SW-1:0] sum_m_re, sum_m_im, sum_p_re, sum_p_im;

    // stage 1: capture x and look up the twiddle for a valid input
    always_comb begin
        s1_vld_d = en;
        s1_i_d   = s1_i_q;
        s1_q_d   = s1_q_q;
        s1_c_d   = s1_c_q;
        s1_s_d   = s1_s_q;
        if (en) begin
            s1_i_d = in_data_i;
            s1_q_d = in_data_q;
            s1_c_d = rom_c[fi_deg];
            s1_s_d = rom_s[fi_deg];
        end
    end

    // stage 2: the four partial products at full precision
    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_ic_d  = s2_ic_q;
        s2_qs_d  = s2_qs_q;
        s2_is_d  = s2_is_q;
        s2_qc_d  = s2_qc_q;
        if (s1_vld_q) begin
            s2_ic_d = PW'(s1_i_q) * PW'(s1_c_q);
            s2_qs_d = PW'(s1_q_q) * PW'(s1_s_q);
            s2_is_d = PW'(s1_i_q) * PW'(s1_s_q);
            s2_qc_d = PW'(s1_q_q) * PW'(s1_c_q);
        end
    end

    // stage 3: x*(C-jS) and x*(C+jS), scaled and saturated; outputs load only on valid
    always_comb begin
        sum_m_re  = SW'(s2_ic_q) + SW'(s2_qs_q);
        sum_m_im  = SW'(s2_qc_q) - SW'(s2_is_q);
        sum_p_re  = SW'(s2_ic_q) - SW'(s2_qs_q);
        sum_p_im  = SW'(s2_qc_q) + SW'(s2_is_q);
        out_vld_d = s2_vld_q;
        out_mi_d  = out_mi_q;
        out_mq_d  = out_mq_q;
        out_pi_d  = out_pi_q;
        out_pq_d  = out_pq_q;
        if (s2_vld_q) begin
            if (SWAP_OUT) begin
                out_mi_d = scale_sat(sum_p_re);
                out_mq_d = scale_sat(sum_p_im);
                out_pi_d = scale_sat(sum_m_re);
                out_pq_d = scale_sat(sum_m_im);
            end else begin
                out_mi_d = scale_sat(sum_m_re);
                out_mq_d = scale_sat(sum_m_im);
                out_pi_d = scale_sat(sum_p_re);
                out_pq_d = scale_sat(sum_p_im);
            end
        end
    end

    // all pipeline flops; reset clears every stage so no stale valid survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s1_c_q    <= '0;
            s1_s_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_ic_q   <= '0;
            s2_qs_q   <= '0;
            s2_is_q   <= '0;
            s2_qc_q   <= '0;
            out_vld_q <= 1'b0;
            out_mi_q  <= '0;
            out_mq_q  <= '0;
            out_pi_q  <= '0;
            out_pq_q  <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_i_q    <= s1_i_d;
            s1_q_q    <= s1_q_d;
            s1_c_q    <= s1_c_d;
            s1_s_q    <= s1_s_d;
            s2_vld_q  <= s2_vld_d;
            s2_ic_q   <= s2_ic_d;
            s2_qs_q   <= s2_qs_d;
            s2_is_q   <= s2_is_d;
            s2_qc_q   <= s2_qc_d;
            out_vld_q <= out_vld_d;
            out_mi_q  <= out_mi_d;
            out_mq_q  <= out_mq_d;
            out_pi_q  <= out_pi_d;
            out_pq_q  <= out_pq_d;
        end
    end

    assign out_data_minus_i = out_mi_q;
    assign out_data_minus_q = out_mq_q;
    assign out_data_plus_i  = out_pi_q;
    assign out_data_plus_q  = out_pq_q;
    assign outValid         = out_vld_q;

endmodule

// File: tb/tb_mult_complex_e.sv
// Bench for mult_complex_e: three variants (forvard/add, forvard/false, inverse/add) share one stimulus.
// Expected results come from a trig-based reference model and are queued at issue time.
// A separate monitor pops the queue when a result is due and also checks that idle outputs hold.
module tb_mult_complex_e;

    localparam int W    = 16;
    localparam int SF   = 3;
    localparam int NPTS = 1 << SF;
    localparam int ND   = 3;
    localparam int LAT  = 3;   // rising edges from the one capturing en to the one raising outValid
    localparam real PI  = 3.14159265358979323846;

    typedef struct packed {
        int mi;
        int mq;
        int pi;
        int pq;
    } res_t;

    typedef struct packed {
        res_t [ND-1:0] r;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic [W-1:0]  in_i;
    logic [W-1:0]  in_q;
    logic [SF-1:0] fi;
    logic [ND-1:0][W-1:0] o_mi, o_mq, o_pi, o_pq;
    logic [ND-1:0]        o_vld;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_complex_e #(.SIZE_DATA_FI(SF), .DATA_FFT_SIZE(W), .TYPE("forvard"), .COMPENS_FP("add")) u_fwd_add (
        .clk(clk), .reset(reset), .en(en), .in_data_i(in_i), .in_data_q(in_q), .fi_deg(fi),
        .out_data_minus_i(o_mi[0]), .out_data_minus_q(o_mq[0]),
        .out_data_plus_i(o_pi[0]), .out_data_plus_q(o_pq[0]), .outValid(o_vld[0]));

    mult_complex_e #(.SIZE_DATA_FI(SF), .DATA_FFT_SIZE(W), .TYPE("forvard"), .COMPENS_FP("false")) u_fwd_trunc (
        .clk(clk), .reset(reset), .en(en), .in_data_i(in_i), .in_data_q(in_q), .fi_deg(fi),
        .out_data_minus_i(o_mi[1]), .out_data_minus_q(o_mq[1]),
        .out_data_plus_i(o_pi[1]), .out_data_plus_q(o_pq[1]), .outValid(o_vld[1]));

    mult_complex_e #(.SIZE_DATA_FI(SF), .DATA_FFT_SIZE(W), .TYPE("inverse"), .COMPENS_FP("add")) u_inv_add (
        .clk(clk), .reset(reset), .en(en), .in_data_i(in_i), .in_data_q(in_q), .fi_deg(fi),
        .out_data_minus_i(o_mi[2]), .out_data_minus_q(o_mq[2]),
        .out_data_plus_i(o_pi[2]), .out_data_plus_q(o_pq[2]), .outValid(o_vld[2]));

    task automatic chk(input string name, input int d, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, expv, $time);
        end
    endtask

    // divide by 2^15 (optionally rounding half-up), floor, then clamp to the output range
    function automatic int scale(input longint v, input bit rnd);
        longint t;
        t = rnd ? v + 64'sd16384 : v;
        t = t >>> 15;
        if (t > longint'((1 << (W - 1)) - 1)) return (1 << (W - 1)) - 1;
        if (t < -longint'(1 << (W - 1)))     return -(1 << (W - 1));
        return int'(t);
    endfunction

    // x*e^(-j*theta) and x*e^(+j*theta) from the trig definition
    function automatic res_t model(input int xi, input int xq, input int k, input bit inv, input bit rnd);
        real    th;
        longint c, s, m_re, m_im, p_re, p_im;
        res_t   r;
        th   = 2.0 * PI * real'(k) / real'(NPTS);
        c    = longint'(int'(32768.0 * $cos(th)));
        s    = longint'(int'(32768.0 * $sin(th)));
        m_re = longint'(xi) * c + longint'(xq) * s;
        m_im = longint'(xq) * c - longint'(xi) * s;
        p_re = longint'(xi) * c - longint'(xq) * s;
        p_im = longint'(xq) * c + longint'(xi) * s;
        if (inv) begin
            r.mi = scale(p_re, rnd); r.mq = scale(p_im, rnd);
            r.pi = scale(m_re, rnd); r.pq = scale(m_im, rnd);
        end else begin
            r.mi = scale(m_re, rnd); r.mq = scale(m_im, rnd);
            r.pi = scale(p_re, rnd); r.pq = scale(p_im, rnd);
        end
        return r;
    endfunction

    function automatic res_t dut_res(input int d);
        res_t r;
        r.mi = int'($signed(o_mi[d]));
        r.mq = int'($signed(o_mq[d]));
        r.pi = int'($signed(o_pi[d]));
        r.pq = int'($signed(o_pq[d]));
        return r;
    endfunction

    task automatic chk_res(input string name, input int d, input res_t act, input res_t expv);
        chk({name, "_minus_i"}, d, act.mi, expv.mi);
        chk({name, "_minus_q"}, d, act.mq, expv.mq);
        chk({name, "_plus_i"},  d, act.pi, expv.pi);
        chk({name, "_plus_q"},  d, act.pq, expv.pq);
    endtask

    // drive one cycle of input after the falling edge; queue the expected result if valid
    task automatic send(input bit e, input int xi, input int xq, input int k);
        exp_t x;
        @(negedge clk);
        en   = e;
        in_i = xi[W-1:0];
        in_q = xq[W-1:0];
        fi   = k[SF-1:0];
        if (e) begin
            x.r[0] = model(xi, xq, k, 1'b0, 1'b1);
            x.r[1] = model(xi, xq, k, 1'b0, 1'b0);
            x.r[2] = model(xi, xq, k, 1'b1, 1'b1);
            x.cyc  = cyc;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 0, 0);
    endtask

    function automatic int rval();
        case ($urandom_range(0, 7))
            0:       return (1 << (W - 1)) - 1;
            1:       return -(1 << (W - 1));
            default: return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
        endcase
    endfunction

    // monitor: at each falling edge decide whether a result is due and compare
    initial begin : monitor
        res_t last [ND];
        exp_t e;
        bit   due;
        for (int d = 0; d < ND; d++) last[d] = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int d = 0; d < ND; d++) last[d] = '0;
            end else begin
                while (sb.size() > 0 && sb[0].cyc + LAT < cyc) begin
                    e = sb.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_result: issued at cycle %0d, never seen valid (t=%0t)", e.cyc, $time);
                end
                due = (sb.size() > 0) && (sb[0].cyc + LAT == cyc);
                for (int d = 0; d < ND; d++) chk("out_valid", d, int'(o_vld[d]), int'(due));
                if (due) begin
                    e = sb.pop_front();
                    for (int d = 0; d < ND; d++) begin
                        chk_res("result", d, dut_res(d), e.r[d]);
                        last[d] = e.r[d];
                    end
                end else begin
                    for (int d = 0; d < ND; d++) chk_res("hold", d, dut_res(d), last[d]);
                end
            end
        end
    end

    int dir_i [9] = '{749, 749, 749, 749, 749, 1, 32767, -32768, -32768};
    int dir_q [9] = '{749, 749, 749, 749, 749, 0, 32767, -32768, 0};
    int dir_k [9] = '{0,   2,   1,   4,   6,   1, 1,     3,      5};

    initial begin : stimulus
        reset = 1'b1;
        en    = 1'b0;
        in_i  = '0;
        in_q  = '0;
        fi    = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("reset_valid", d, int'(o_vld[d]), 0);
            chk_res("reset", d, dut_res(d), '0);
        end
        @(posedge clk);
        #2 reset = 1'b0;

        // isolated directed samples from the plan
        for (int t = 0; t < 9; t++) begin
            send(1'b1, dir_i[t], dir_q[t], dir_k[t]);
            idle(4);
        end

        // back-to-back phase sweep
        for (int k = 0; k < NPTS; k++) send(1'b1, 749, 749, k);
        idle(4);

        // random traffic with gaps
        for (int t = 0; t < 300; t++) begin
            send($urandom_range(0, 3) != 0, rval(), rval(), int'($urandom_range(0, NPTS - 1)));
        end

        // reset in the middle of a stream
        for (int t = 0; t < 6; t++) send(1'b1, rval(), rval(), int'($urandom_range(0, NPTS - 1)));
        @(posedge clk);
        #2 reset = 1'b1;
        en = 1'b0;
        sb.delete();
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("midreset_valid", d, int'(o_vld[d]), 0);
            chk_res("midreset", d, dut_res(d), '0);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        idle(6);
        send(1'b1, 749, 749, 2);
        idle(2);
        send(1'b1, 1, 0, 1);
        idle(5);

        // bounded drain of anything still outstanding
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
